// File: rtl/down_scale_avg2x2.sv
// 2x2 box-filter decimator: even rows go to the line buffer, odd rows are summed
// against the stored row and every odd-row pixel pair yields one rounded average.
module down_scale_avg2x2 #(
   parameter int WIDTH = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [WIDTH-1:0] in_data,
   output logic             lb_we,
   output logic [WIDTH-1:0] lb_din,
   input  logic             lb_ready,
   output logic             lb_rd,
   input  logic [WIDTH-1:0] lb_dout,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_eof,
   output logic             err
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

   logic [CW-1:0]    col, cur_col;
   logic [RW-1:0]    row, cur_row;
   logic             sof_hit, last_col, last_row, even_wr;

   logic             s1_vld, s1_col0, s1_last, s1_eof;
   logic [WIDTH-1:0] s1_pix;
   logic [WIDTH:0]   part, pair_sum;
   logic             part_vld;
   logic [WIDTH+1:0] sum4;

   // A start-of-frame pixel is itself col 0 / row 0, so position is resolved
   // before the registered counters are consulted.
   always_comb begin
      sof_hit  = in_valid & in_sof;
      cur_col  = sof_hit ? '0 : col;
      cur_row  = sof_hit ? '0 : row;
      last_col = (cur_col == COL_MAX);
      last_row = (cur_row == ROW_MAX);
      lb_rd    = in_valid & cur_row[0];
      even_wr  = in_valid & ~cur_row[0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         col <= last_col ? '0 : cur_col + 1'b1;
         if (last_col)
            row <= last_row ? '0 : cur_row + 1'b1;
         else
            row <= cur_row;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lb_we  <= 1'b0;
         lb_din <= '0;
      end else begin
         lb_we <= even_wr;
         if (even_wr)
            lb_din <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         err <= 1'b0;
      else if (lb_rd && !lb_ready)
         err <= 1'b1;
   end

   // Stage 1 lines the live pixel up with lb_dout, which returns a cycle after lb_rd.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_pix  <= '0;
         s1_col0 <= 1'b0;
         s1_last <= 1'b0;
         s1_eof  <= 1'b0;
      end else begin
         s1_vld <= lb_rd;
         if (lb_rd) begin
            s1_pix  <= in_data;
            s1_col0 <= cur_col[0];
            s1_last <= last_col;
            s1_eof  <= last_col & last_row;
         end
      end
   end

   always_comb begin
      pair_sum = (WIDTH+1)'(s1_pix) + (WIDTH+1)'(lb_dout);
      sum4     = (WIDTH+2)'(part) + (WIDTH+2)'(s1_pix) + (WIDTH+2)'(lb_dout) + (WIDTH+2)'(2);
   end

   // part_vld guards against completing a pair whose even half belonged to an
   // aborted frame; a new frame start wins over a same-cycle even-column update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         part      <= '0;
         part_vld  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_eof   <= 1'b0;
         if (s1_vld && !s1_col0)
            part <= pair_sum;
         if (sof_hit)
            part_vld <= 1'b0;
         else if (s1_vld && !s1_col0)
            part_vld <= 1'b1;
         if (s1_vld && s1_col0 && part_vld) begin
            out_valid <= 1'b1;
            out_data  <= sum4[WIDTH+1:2];
            out_last  <= s1_last;
            out_eof   <= s1_eof;
         end
      end
   end

endmodule

// File: tb/tb_down_scale_avg2x2.sv
// Scoreboard bench for down_scale_avg2x2 on a small 8x4 raster with a behavioural line buffer.
module tb_down_scale_avg2x2;

   localparam int WIDTH = 8;
   localparam int IMG_W = 8;
   localparam int IMG_H = 4;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             last;
      logic             eof;
      int               cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_sof = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             lb_we, lb_rd, lb_ready;
   logic [WIDTH-1:0] lb_din, lb_dout;
   logic             out_valid, out_last, out_eof, err;
   logic [WIDTH-1:0] out_data;

   down_scale_avg2x2 #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .lb_we(lb_we), .lb_din(lb_din), .lb_ready(lb_ready), .lb_rd(lb_rd), .lb_dout(lb_dout),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_eof(out_eof),
      .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Line buffer model: sequential write/read pointers, one-cycle read latency.
   logic [WIDTH-1:0] lb_mem [IMG_W];
   int   wptr, rptr;
   logic ready_en = 1'b1;
   assign lb_ready = ready_en;

   always @(posedge clk) begin
      if (!rst_n) begin
         wptr    <= 0;
         rptr    <= 0;
         lb_dout <= '0;
      end else begin
         if (lb_we) lb_mem[wptr] <= lb_din;
         if (in_valid && in_sof) wptr <= 0;
         else if (lb_we) wptr <= (wptr + 1) % IMG_W;
         if (in_valid && in_sof) rptr <= 0;
         else if (lb_rd) begin
            lb_dout <= lb_mem[rptr];
            rptr    <= (rptr + 1) % IMG_W;
         end
      end
   end

   exp_t             sbq[$];
   logic [WIDTH+1:0] obs[$];
   int               n_cmp = 0;
   int               n_fail = 0;
   int               we_cnt = 0;
   logic             sb_discard = 1'b0;

   logic [WIDTH-1:0] img [IMG_H][IMG_W];
   int               mline [IMG_W];
   int               m_col, m_row, m_part;
   logic             m_pvld;

   task automatic model_reset();
      m_col = 0; m_row = 0; m_part = 0; m_pvld = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sof   = 1'b0;
      end
   endtask

   task automatic drive_pix(input logic [WIDTH-1:0] d, input logic sof, input int gap);
      exp_t e;
      idle(gap);
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = d;
      if (sof) begin m_col = 0; m_row = 0; m_pvld = 1'b0; end
      if (m_row % 2 == 0)
         mline[m_col] = int'(d);
      else if (m_col % 2 == 0) begin
         m_part = int'(d) + mline[m_col];
         m_pvld = 1'b1;
      end else if (m_pvld && !sb_discard) begin
         e.data = WIDTH'((m_part + int'(d) + mline[m_col] + 2) / 4);
         e.last = (m_col == IMG_W - 1);
         e.eof  = (m_col == IMG_W - 1) && (m_row == IMG_H - 1);
         e.cyc  = cyc + 2;
         sbq.push_back(e);
      end
      m_col++;
      if (m_col == IMG_W) begin
         m_col = 0;
         m_row = (m_row + 1) % IMG_H;
      end
   endtask

   task automatic send_range(input int start, input int stop, input int max_gap, input logic use_sof);
      for (int p = start; p < stop; p++)
         drive_pix(img[p / IMG_W][p % IMG_W], use_sof && (p == 0), int'($urandom_range(0, max_gap)));
   endtask

   task automatic fill_random();
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++)
            img[r][c] = WIDTH'($urandom_range(0, 255));
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sbq.delete();
      model_reset();
   endtask

   task automatic sb_monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (lb_we) we_cnt++;
         if (out_valid) begin
            obs.push_back({out_data, out_last, out_eof});
            if (!sb_discard) begin
               n_cmp++;
               if (sbq.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_extra: unexpected output data=%0d last=%0b eof=%0b at cycle %0d",
                           out_data, out_last, out_eof, cyc);
               end else begin
                  e = sbq.pop_front();
                  if ({out_data, out_last, out_eof} !== {e.data, e.last, e.eof} || cyc != e.cyc) begin
                     n_fail++;
                     $display("FAIL sb_output: got data=%0d last=%0b eof=%0b cyc=%0d, want data=%0d last=%0b eof=%0b cyc=%0d",
                              out_data, out_last, out_eof, cyc, e.data, e.last, e.eof, e.cyc);
                  end
               end
            end
         end
      end
   endtask

   task automatic check_drained(input string name);
      n_cmp++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d expected outputs never appeared, want 0", name, sbq.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({lb_we, lb_din} !== '0) begin
         n_fail++; $display("FAIL reset_lb: got we=%b din=%0d, want 0/0", lb_we, lb_din);
      end
      n_cmp++;
      if ({out_valid, out_data, out_last, out_eof} !== '0) begin
         n_fail++; $display("FAIL reset_out: got valid=%b data=%0d last=%b eof=%b, want all 0",
                            out_valid, out_data, out_last, out_eof);
      end
      n_cmp++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL reset_err: got %b, want 0", err);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      for (int c = 0; c < IMG_W; c++) begin
         img[0][c] = 8'd10; img[1][c] = 8'd20; img[2][c] = 8'd30; img[3][c] = 8'd50;
      end
      obs.delete(); we_cnt = 0;
      send_range(0, IMG_W * IMG_H, 0, 1'b1);
      idle(4);
      n_cmp++;
      if (obs.size() != 8) begin
         n_fail++; $display("FAIL basic_count: got %0d outputs, want 8", obs.size());
      end else begin
         n_cmp++;
         if (obs[3] !== {8'd15, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL basic_row0_last: got %h, want %h", obs[3], {8'd15, 1'b1, 1'b0});
         end
         n_cmp++;
         if (obs[7] !== {8'd40, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL basic_eof: got %h, want %h", obs[7], {8'd40, 1'b1, 1'b1});
         end
      end
      n_cmp++;
      if (we_cnt != 16) begin
         n_fail++; $display("FAIL basic_lb_we: got %0d writes, want 16", we_cnt);
      end
      check_drained("basic");
   endtask

   task automatic test_rounding();
      int rexp [4];
      rexp = '{2, 0, 1, 255};
      fill_random();
      img[0][0] = 8'd1;   img[0][1] = 8'd2;   img[1][0] = 8'd2;   img[1][1] = 8'd2;
      img[0][2] = 8'd0;   img[0][3] = 8'd0;   img[1][2] = 8'd0;   img[1][3] = 8'd1;
      img[0][4] = 8'd0;   img[0][5] = 8'd1;   img[1][4] = 8'd1;   img[1][5] = 8'd1;
      img[0][6] = 8'd255; img[0][7] = 8'd255; img[1][6] = 8'd255; img[1][7] = 8'd255;
      obs.delete();
      send_range(0, IMG_W * IMG_H, 0, 1'b1);
      idle(4);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= obs.size()) begin
            n_fail++; $display("FAIL round_%0d: missing output, want %0d", i, rexp[i]);
         end else if (obs[i][WIDTH+1:2] !== WIDTH'(rexp[i])) begin
            n_fail++; $display("FAIL round_%0d: got %0d, want %0d", i, obs[i][WIDTH+1:2], rexp[i]);
         end
      end
      check_drained("round");
   endtask

   task automatic test_random_gaps();
      obs.delete();
      for (int f = 0; f < 20; f++) begin
         fill_random();
         send_range(0, IMG_W * IMG_H, 2, 1'b1);
      end
      idle(4);
      n_cmp++;
      if (obs.size() != 160) begin
         n_fail++; $display("FAIL random_count: got %0d outputs, want 160", obs.size());
      end
      check_drained("random");
   endtask

   task automatic test_err();
      reset_dut();
      fill_random();
      send_range(0, IMG_W, 0, 1'b1);
      ready_en   = 1'b0;
      sb_discard = 1'b1;
      drive_pix(img[1][0], 1'b0, 0);
      n_cmp++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL err_before: got %b, want 0", err);
      end
      drive_pix(img[1][1], 1'b0, 0);
      n_cmp++;
      if (err !== 1'b1) begin
         n_fail++; $display("FAIL err_set: got %b, want 1", err);
      end
      send_range(IMG_W + 2, IMG_W * IMG_H, 1, 1'b0);
      idle(4);
      n_cmp++;
      if (err !== 1'b1) begin
         n_fail++; $display("FAIL err_sticky: got %b, want 1", err);
      end
      ready_en = 1'b1;
      reset_dut();
      sb_discard = 1'b0;
      n_cmp++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL err_clear: got %b, want 0", err);
      end
   endtask

   task automatic test_sof_midline();
      reset_dut();
      fill_random();
      obs.delete();
      send_range(0, IMG_W + 5, 0, 1'b1);
      drive_pix(img[0][0], 1'b1, 0);
      #1;
      n_cmp++;
      if (lb_rd !== 1'b0) begin
         n_fail++; $display("FAIL sof_lb_rd: got %b, want 0", lb_rd);
      end
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0;
      n_cmp++;
      if ({lb_we, lb_din} !== {1'b1, img[0][0]}) begin
         n_fail++; $display("FAIL sof_lb_we: got we=%b din=%0d, want we=1 din=%0d", lb_we, lb_din, img[0][0]);
      end
      send_range(1, IMG_W * IMG_H, 0, 1'b0);
      idle(4);
      n_cmp++;
      if (obs.size() != 10) begin
         n_fail++; $display("FAIL sof_count: got %0d outputs, want 10", obs.size());
      end
      check_drained("sof");
   endtask

   task automatic test_reset_midframe();
      reset_dut();
      fill_random();
      send_range(0, IMG_W + 2, 0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0; rst_n = 1'b0;
      sbq.delete();
      model_reset();
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_data, out_last, out_eof, lb_we} !== '0) begin
         n_fail++; $display("FAIL rstmid_out: got valid=%b data=%0d last=%b eof=%b we=%b, want all 0",
                            out_valid, out_data, out_last, out_eof, lb_we);
      end
      rst_n = 1'b1;
      fill_random();
      obs.delete();
      send_range(0, IMG_W * IMG_H, 1, 1'b0);
      idle(4);
      n_cmp++;
      if (obs.size() != 8) begin
         n_fail++; $display("FAIL rstmid_count: got %0d outputs, want 8", obs.size());
      end
      check_drained("rstmid");
   endtask

   initial begin
      model_reset();
      fork
         sb_monitor();
      join_none
      test_reset();
      test_basic();
      test_rounding();
      test_random_gaps();
      test_err();
      test_sof_midline();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
